// File: rtl/ptp_egress_arbiter.sv
// Store-and-forward two-input packet arbiter toward the LCM egress.
// Input 0 (PTP TX) has strict priority with a starvation guard; round robin is selectable.

module ptp_egress_fifo #(
  parameter int W  = 134,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic          empty,
  output logic          wr_drop,
  output logic [AW:0]   next_cnt
);
  localparam int DEPTH = 1 << AW;

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr, cnt;
  logic         full, wr_ok, rd_ok;

  assign cnt      = wr_ptr - rd_ptr;
  assign empty    = (cnt == '0);
  assign full     = (cnt == (AW+1)'(DEPTH));
  assign rd_ok    = rd_en && !empty;
  // A simultaneous pop frees the slot, so a write at full is still accepted then.
  assign wr_ok    = wr_en && (!full || rd_ok);
  assign wr_drop  = wr_en && !wr_ok;
  assign next_cnt = (wr_ptr + (AW+1)'(wr_ok)) - (rd_ptr + (AW+1)'(rd_ok));
  assign rd_data  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_ok) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end
endmodule

module ptp_egress_arbiter #(
  parameter int DATA_AW    = 8,
  parameter int VALID_AW   = 5,
  parameter int ALF_MARGIN = 32,
  parameter int PRIO_MODE  = 1,
  parameter int MAX_CONSEC = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in0_data_wr,
  input  logic [133:0] in0_data,
  input  logic         in0_data_valid,
  input  logic         in0_data_valid_wr,
  output logic         in0_alf,
  input  logic         in1_data_wr,
  input  logic [133:0] in1_data,
  input  logic         in1_data_valid,
  input  logic         in1_data_valid_wr,
  output logic         in1_alf,
  output logic         out_data_wr,
  output logic [133:0] out_data,
  output logic         out_data_valid,
  output logic         out_data_valid_wr,
  input  logic         out_alf,
  output logic         in0_ovf,
  output logic         in1_ovf,
  output logic [31:0]  grant_cnt0,
  output logic [31:0]  grant_cnt1
);
  // Strobe semantics: every *_wr is a single-cycle push with no back-pressure; the
  // writer honours *_alf. data_valid is meaningful only while data_valid_wr is high.
  typedef enum logic [1:0] {IDLE, SEND, DROP} state_t;

  state_t         state, state_nxt;
  logic           d_wr [2], d_rd [2], d_empty [2], d_drop [2];
  logic           v_wr [2], v_rd [2], v_empty [2], v_drop [2], v_in [2], v_out [2];
  logic [133:0]   d_in [2], d_out [2];
  logic [DATA_AW:0]  d_ncnt [2];
  logic [VALID_AW:0] v_ncnt [2];
  logic           sel, sel_nxt, rr_ptr, rr_nxt, win, elig0, elig1;
  logic [7:0]     consec, consec_nxt;
  logic           owr_nxt, ovwr_nxt, inc0, inc1;
  logic [133:0]   odata_nxt;

  assign d_wr[0] = in0_data_wr;       assign d_wr[1] = in1_data_wr;
  assign d_in[0] = in0_data;          assign d_in[1] = in1_data;
  assign v_wr[0] = in0_data_valid_wr; assign v_wr[1] = in1_data_valid_wr;
  assign v_in[0] = in0_data_valid;    assign v_in[1] = in1_data_valid;

  for (genvar i = 0; i < 2; i++) begin : g_in
    logic              alf_q, ovf_q;
    logic [DATA_AW:0]  d_free;
    logic [VALID_AW:0] v_free;

    ptp_egress_fifo #(.W(134), .AW(DATA_AW)) u_data (
      .clk(clk), .rst_n(rst_n), .wr_en(d_wr[i]), .wr_data(d_in[i]), .rd_en(d_rd[i]),
      .rd_data(d_out[i]), .empty(d_empty[i]), .wr_drop(d_drop[i]), .next_cnt(d_ncnt[i])
    );
    ptp_egress_fifo #(.W(1), .AW(VALID_AW)) u_valid (
      .clk(clk), .rst_n(rst_n), .wr_en(v_wr[i]), .wr_data(v_in[i]), .rd_en(v_rd[i]),
      .rd_data(v_out[i]), .empty(v_empty[i]), .wr_drop(v_drop[i]), .next_cnt(v_ncnt[i])
    );

    // Occupancy after this edge, so alf tracks the FIFO without an extra cycle of lag.
    assign d_free = (DATA_AW+1)'(1 << DATA_AW) - d_ncnt[i];
    assign v_free = (VALID_AW+1)'(1 << VALID_AW) - v_ncnt[i];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        alf_q <= 1'b0;
        ovf_q <= 1'b0;
      end else begin
        alf_q <= (d_free < (DATA_AW+1)'(ALF_MARGIN)) || (v_free < (VALID_AW+1)'(2));
        if (d_drop[i] || v_drop[i]) ovf_q <= 1'b1;
      end
    end
  end

  assign in0_alf = g_in[0].alf_q;
  assign in1_alf = g_in[1].alf_q;
  assign in0_ovf = g_in[0].ovf_q;
  assign in1_ovf = g_in[1].ovf_q;

  assign elig0 = !v_empty[0];
  assign elig1 = !v_empty[1];

  always_comb begin
    state_nxt  = state;
    sel_nxt    = sel;
    rr_nxt     = rr_ptr;
    consec_nxt = consec;
    win        = 1'b0;
    d_rd[0]    = 1'b0;
    d_rd[1]    = 1'b0;
    v_rd[0]    = 1'b0;
    v_rd[1]    = 1'b0;
    owr_nxt    = 1'b0;
    ovwr_nxt   = 1'b0;
    odata_nxt  = out_data;
    inc0       = 1'b0;
    inc1       = 1'b0;
    case (state)
      IDLE: begin
        if (!out_alf && (elig0 || elig1)) begin
          if (PRIO_MODE != 0) win = !(elig0 && !(elig1 && consec == 8'(MAX_CONSEC)));
          else                win = (elig0 && elig1) ? !rr_ptr : elig1;
          v_rd[win] = 1'b1;
          sel_nxt   = win;
          rr_nxt    = win;
          if (PRIO_MODE != 0) consec_nxt = (!win && elig1) ? consec + 8'd1 : 8'd0;
          state_nxt = v_out[win] ? SEND : DROP;
        end
      end
      SEND, DROP: begin
        if (!d_empty[sel]) begin
          d_rd[sel] = 1'b1;
          if (state == SEND) begin
            owr_nxt   = 1'b1;
            odata_nxt = d_out[sel];
          end
          if (d_out[sel][133:132] == 2'b10) begin
            state_nxt = IDLE;
            if (state == SEND) begin
              ovwr_nxt = 1'b1;
              inc0     = !sel;
              inc1     = sel;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      sel               <= 1'b0;
      rr_ptr            <= 1'b1;
      consec            <= 8'd0;
      out_data_wr       <= 1'b0;
      out_data          <= '0;
      out_data_valid    <= 1'b0;
      out_data_valid_wr <= 1'b0;
      grant_cnt0        <= 32'd0;
      grant_cnt1        <= 32'd0;
    end else begin
      state             <= state_nxt;
      sel               <= sel_nxt;
      rr_ptr            <= rr_nxt;
      consec            <= consec_nxt;
      out_data_wr       <= owr_nxt;
      out_data          <= odata_nxt;
      out_data_valid    <= ovwr_nxt;
      out_data_valid_wr <= ovwr_nxt;
      grant_cnt0        <= grant_cnt0 + 32'(inc0);
      grant_cnt1        <= grant_cnt1 + 32'(inc1);
    end
  end
endmodule
